// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_round_ctrl
// Purpose  : Round sequencer for the switch-matching game. Draws a target per
//            round, opens a fixed response window, judges the player's guess
//            and keeps the running and best scores over ROUNDS rounds.
// Revision : 1.0  initial release
// ============================================================================
module game_round_ctrl #(
  parameter int unsigned ROUNDS = 8,           // rounds per game, 1..15
  parameter int unsigned WINDOW = 50_000_000   // response window in cycles, >= 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,        // asynchronous, active-low
  input  logic       start_p_i,
  input  logic       submit_p_i,
  input  logic [3:0] sw_i,
  input  logic [3:0] rand_in_i,
  output logic [3:0] target_o,
  output logic [3:0] score_o,
  output logic [3:0] high_score_o,
  output logic [3:0] round_no_o,
  output logic       busy_o,
  output logic       game_over_o,
  output logic       hit_p_o,
  output logic       miss_p_o
);

  // Window counter is loaded with WINDOW-1 and times out when it reads zero,
  // so it only needs to represent 0..WINDOW-1.
  localparam int unsigned     CNT_W      = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WINDOW - 1);
  localparam logic [3:0]      LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [3:0]      SCORE_MAX  = 4'hF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [3:0]       target_q, target_d;
  logic [3:0]       score_q,  score_d;
  logic [3:0]       high_q,   high_d;
  logic [3:0]       round_q,  round_d;
  logic             busy_q,   busy_d;
  logic             over_q,   over_d;
  logic             hit_q,    hit_d;
  logic             miss_q,   miss_d;

  // Next-state and datapath decisions for the round sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    score_d  = score_q;
    high_d   = high_q;
    round_d  = round_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_p_i) begin
          state_d = S_LOAD;
          score_d = 4'd0;
          round_d = 4'd0;
        end
      end

      S_LOAD: begin
        // A zero draw is remapped so the target is always a reachable 1..15.
        target_d = (rand_in_i == 4'd0) ? 4'd1 : rand_in_i;
        cnt_d    = CNT_LOAD;
        state_d  = S_ARMED;
      end

      S_ARMED: begin
        // A submit on the last window cycle wins over the timeout.
        if (submit_p_i) begin
          state_d = S_NEXT;
          if (sw_i == target_q) begin
            hit_d   = 1'b1;
            score_d = (score_q == SCORE_MAX) ? SCORE_MAX : score_q + 4'd1;
          end else begin
            miss_d = 1'b1;
          end
        end else if (cnt_q == '0) begin
          miss_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_NEXT: begin
        if (round_q == LAST_ROUND) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_LOAD;
        end
      end

      S_DONE: begin
        // Score is frozen in DONE, so comparing on every DONE cycle has the
        // same effect as a single update on the first one.
        if (score_q > high_q) begin
          high_d = score_q;
        end
        if (start_p_i) begin
          state_d = S_LOAD;
          score_d = 4'd0;
          round_d = 4'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they can be registered
  // alongside it and stay glitch-free at the outputs.
  always_comb begin
    busy_d = (state_d == S_LOAD) || (state_d == S_ARMED) || (state_d == S_NEXT);
    over_d = (state_d == S_DONE);
  end

  // State and output registers; reset clears everything including the best score.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      target_q <= 4'd0;
      score_q  <= 4'd0;
      high_q   <= 4'd0;
      round_q  <= 4'd0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      score_q  <= score_d;
      high_q   <= high_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign target_o     = target_q;
  assign score_o      = score_q;
  assign high_score_o = high_q;
  assign round_no_o   = round_q;
  assign busy_o       = busy_q;
  assign game_over_o  = over_q;
  assign hit_p_o      = hit_q;
  assign miss_p_o     = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_round_ctrl
// Purpose  : Directed self-checking bench for game_round_ctrl with a
//            scoreboard of expected judgement pulses (ROUNDS=3, WINDOW=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_game_round_ctrl;

  localparam int unsigned ROUNDS = 3;
  localparam int unsigned WINDOW = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_p_i;
  logic       submit_p_i;
  logic [3:0] sw_i;
  logic [3:0] rand_in_i;
  logic [3:0] target_o;
  logic [3:0] score_o;
  logic [3:0] high_score_o;
  logic [3:0] round_no_o;
  logic       busy_o;
  logic       game_over_o;
  logic       hit_p_o;
  logic       miss_p_o;

  typedef struct {
    logic       hit;
    logic [3:0] score;
    logic [3:0] round;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  game_round_ctrl #(.ROUNDS(ROUNDS), .WINDOW(WINDOW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_p_i    (start_p_i),
    .submit_p_i   (submit_p_i),
    .sw_i         (sw_i),
    .rand_in_i    (rand_in_i),
    .target_o     (target_o),
    .score_o      (score_o),
    .high_score_o (high_score_o),
    .round_no_o   (round_no_o),
    .busy_o       (busy_o),
    .game_over_o  (game_over_o),
    .hit_p_o      (hit_p_o),
    .miss_p_o     (miss_p_o)
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_target"},    32'(target_o),     0);
    check({tag, "_score"},     32'(score_o),      0);
    check({tag, "_high"},      32'(high_score_o), 0);
    check({tag, "_round"},     32'(round_no_o),   0);
    check({tag, "_busy"},      32'(busy_o),       0);
    check({tag, "_game_over"}, 32'(game_over_o),  0);
    check({tag, "_hit"},       32'(hit_p_o),      0);
    check({tag, "_miss"},      32'(miss_p_o),     0);
  endtask

  // Scoreboard: every judgement pulse must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && (hit_p_o === 1'b1 || miss_p_o === 1'b1)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, hit_p_o, miss_p_o}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pulse", {30'd0, hit_p_o, miss_p_o}, {30'd0, mon_e.hit, !mon_e.hit});
        check("sb_score", 32'(score_o), 32'(mon_e.score));
        check("sb_round", 32'(round_no_o), 32'(mon_e.round));
      end
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_ni     = 1'b0;
    start_p_i  = 1'b0;
    submit_p_i = 1'b0;
    sw_i       = 4'd0;
    rand_in_i  = 4'd0;

    // ---- Reset holds everything at zero even with buttons pressed ----
    repeat (2) tick();
    start_p_i  = 1'b1;
    submit_p_i = 1'b1;
    repeat (3) tick();
    check_all_zero("rst_hold");
    start_p_i  = 1'b0;
    submit_p_i = 1'b0;
    rst_ni     = 1'b1;
    tick();
    // Submit in IDLE must be ignored.
    submit_p_i = 1'b1;
    tick();
    submit_p_i = 1'b0;
    tick();
    check("idle_busy", 32'(busy_o), 0);
    check("idle_score", 32'(score_o), 0);

    // ---- Game 1: three hits on the 2nd ARMED cycle ----
    rand_in_i = 4'd5;
    sw_i      = 4'd5;
    start_p_i = 1'b1;
    tick();                              // LOAD
    start_p_i = 1'b0;
    check("g1_load_busy", 32'(busy_o), 1);
    check("g1_load_round", 32'(round_no_o), 0);
    tick();                              // ARMED
    check("g1_target", 32'(target_o), 5);
    for (int r = 0; r < 3; r++) begin
      tick();                            // 1st ARMED cycle sampled
      submit_p_i = 1'b1;
      sb_q.push_back('{hit: 1'b1, score: 4'(r + 1), round: 4'(r)});
      tick();                            // judged on 2nd ARMED cycle
      submit_p_i = 1'b0;
      check("g1_hit", 32'(hit_p_o), 1);
      check("g1_score", 32'(score_o), 32'(r + 1));
      tick();                            // NEXT -> LOAD or DONE
      if (r < 2) begin
        tick();                          // ARMED of next round
        check("g1_round", 32'(round_no_o), 32'(r + 1));
      end
    end
    check("g1_game_over", 32'(game_over_o), 1);
    check("g1_busy_done", 32'(busy_o), 0);
    check("g1_high_before", 32'(high_score_o), 0);
    tick();
    check("g1_high_after", 32'(high_score_o), 3);
    check("g1_score_hold", 32'(score_o), 3);
    check("g1_round_hold", 32'(round_no_o), 2);

    // ---- Game 2, round 0: timeout ----
    rand_in_i = 4'd7;
    sw_i      = 4'd0;
    start_p_i = 1'b1;
    tick();                              // LOAD from DONE
    start_p_i = 1'b0;
    check("g2_score_clr", 32'(score_o), 0);
    check("g2_round_clr", 32'(round_no_o), 0);
    check("g2_busy", 32'(busy_o), 1);
    tick();                              // ARMED entry
    check("g2_target", 32'(target_o), 7);
    sb_q.push_back('{hit: 1'b0, score: 4'd0, round: 4'd0});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (miss_p_o === 1'b1) break;
    end
    check("timeout_cycles", 32'(n), 8);
    check("timeout_score", 32'(score_o), 0);

    // ---- Round 1: zero draw and wrong guess; submit in NEXT ignored ----
    rand_in_i  = 4'd0;
    sw_i       = 4'd2;
    submit_p_i = 1'b1;
    tick();                              // NEXT -> LOAD
    submit_p_i = 1'b0;
    check("next_submit_hit", 32'(hit_p_o), 0);
    check("next_submit_miss", 32'(miss_p_o), 0);
    check("g2_round1", 32'(round_no_o), 1);
    tick();                              // ARMED
    check("zero_target", 32'(target_o), 1);
    sb_q.push_back('{hit: 1'b0, score: 4'd0, round: 4'd1});
    submit_p_i = 1'b1;
    tick();
    submit_p_i = 1'b0;
    check("wrong_miss", 32'(miss_p_o), 1);
    check("wrong_hit", 32'(hit_p_o), 0);
    check("wrong_score", 32'(score_o), 0);
    tick();                              // NEXT -> LOAD
    rand_in_i = 4'd9;
    sw_i      = 4'd9;
    tick();                              // ARMED entry (edge E)
    check("coll_target", 32'(target_o), 9);
    check("coll_round", 32'(round_no_o), 2);

    // ---- Round 2: start in ARMED ignored, submit on the counter==0 cycle ----
    start_p_i = 1'b1;
    tick();                              // E+1
    start_p_i = 1'b0;
    check("armed_start_busy", 32'(busy_o), 1);
    check("armed_start_round", 32'(round_no_o), 2);
    check("armed_start_target", 32'(target_o), 9);
    repeat (6) tick();                   // E+7
    submit_p_i = 1'b1;
    sb_q.push_back('{hit: 1'b1, score: 4'd1, round: 4'd2});
    tick();                              // E+8: last window cycle
    submit_p_i = 1'b0;
    check("coll_hit", 32'(hit_p_o), 1);
    check("coll_miss", 32'(miss_p_o), 0);
    check("coll_score", 32'(score_o), 1);
    tick();                              // NEXT -> DONE
    check("coll_no_timeout", 32'(miss_p_o), 0);
    check("g2_game_over", 32'(game_over_o), 1);
    tick();
    check("g2_high_kept", 32'(high_score_o), 3);
    check("g2_score", 32'(score_o), 1);

    // ---- Game 3: reset asserted in ARMED ----
    rand_in_i = 4'd3;
    start_p_i = 1'b1;
    tick();
    start_p_i = 1'b0;
    tick();                              // ARMED
    check("g3_high_pre", 32'(high_score_o), 3);
    check("g3_target", 32'(target_o), 3);
    rst_ni = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy_o), 0);
    check("post_rst_high", 32'(high_score_o), 0);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
